// File: rtl/pfifo_pkg.sv
// ---------------------------------------------------------------------------
// pfifo_pkg
// Shared definitions for the packet-FIFO bank read/write helpers.
//   WORD_W  : width of one FIFO word (sop + eop + 16-bit payload)
//   SOP_BIT : start-of-packet flag position inside a word
//   EOP_BIT : end-of-packet flag position inside a word
//   DATA_W  : payload width
//   sched_state_t : scheduler state encoding (IDLE, READ, GAP)
//   calc_port_w   : width needed to index a given number of ports
// ---------------------------------------------------------------------------
package pfifo_pkg;

    localparam int WORD_W  = 18;
    localparam int SOP_BIT = 17;
    localparam int EOP_BIT = 16;
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    // ceil(log2(n)), never less than 1 so a two-port bank still gets a bit
    function automatic int calc_port_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
// Combinational round-robin arbiter. The search starts at the port after
// 'last' and wraps, so the most recently served port has lowest priority.
// Shared by the read-side scheduler and the write-side merger.
// Ports:
//   req     in  PORT_NUM : request per port
//   last    in  PORT_W   : port granted most recently
//   gnt_idx out PORT_W   : winning port (0 when nothing requests)
//   any     out 1        : at least one request is present
// ---------------------------------------------------------------------------
module rr_arb
    import pfifo_pkg::*;
#(
    parameter int PORT_NUM = 4,
    parameter int PORT_W   = 2
) (
    input  logic [PORT_NUM-1:0] req,
    input  logic [PORT_W-1:0]   last,
    output logic [PORT_W-1:0]   gnt_idx,
    output logic                any
);

    // Walk the ring from farthest to nearest offset; the last hit written
    // is the nearest requester after 'last', which is the round-robin winner.
    always_comb begin
        logic [PORT_W-1:0] cand;
        cand    = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = PORT_NUM; i >= 1; i--) begin
            cand = PORT_W'((int'(last) + i) % PORT_NUM);
            if (req[cand]) begin
                gnt_idx = cand;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pfifo_rr_sched.sv
// ---------------------------------------------------------------------------
// pfifo_rr_sched
// Round-robin packet scheduler on the read side of the packet-FIFO bank.
// Grants one FIFO at a time, reads exactly one packet per grant, forwards it
// to a single output stream and checks sop/length framing.
// Ports:
//   clk_125m     in  1           : clock
//   rst_125m     in  1           : asynchronous active-high reset
//   pfifo_empty  in  PORT_NUM    : 0 = FIFO holds at least one full packet
//   pfifo_rdata  in  PORT_NUM*18 : FIFO read data, lane i at [18i+17:18i]
//   pfifo_re     out PORT_NUM    : read enable, at most one bit high
//   dst_afull    in  1           : downstream cannot take another packet
//   dst_vld      out 1           : output word valid
//   dst_data     out 16          : payload
//   dst_sop      out 1           : start of packet
//   dst_eop      out 1           : end of packet (real or forced)
//   dst_port     out PORT_W      : source FIFO of the current word
//   err_sop      out 1           : first word of a packet lacked sop
//   err_len      out 1           : packet cut at MAX_LEN words
//   pkt_total    out 16          : completed packets, wrapping
// ---------------------------------------------------------------------------
module pfifo_rr_sched
    import pfifo_pkg::*;
#(
    parameter int PORT_NUM = 4,
    parameter int PORT_W   = 2,
    parameter int MAX_LEN  = 1024,
    parameter int GAP_CYC  = 2
) (
    input  logic                       clk_125m,
    input  logic                       rst_125m,
    input  logic [PORT_NUM-1:0]        pfifo_empty,
    input  logic [PORT_NUM*WORD_W-1:0] pfifo_rdata,
    output logic [PORT_NUM-1:0]        pfifo_re,
    input  logic                       dst_afull,
    output logic                       dst_vld,
    output logic [DATA_W-1:0]          dst_data,
    output logic                       dst_sop,
    output logic                       dst_eop,
    output logic [PORT_W-1:0]          dst_port,
    output logic                       err_sop,
    output logic                       err_len,
    output logic [15:0]                pkt_total
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    sched_state_t      state;
    logic [PORT_W-1:0] gnt;
    logic [PORT_W-1:0] last_grant;
    logic [PORT_W-1:0] arb_idx;
    logic              arb_any;
    logic [CNT_W-1:0]  wcnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              rd_vld;
    logic [WORD_W-1:0] lane;
    logic              eop_in;
    logic              len_hit;
    logic              pkt_end;

    rr_arb #(
        .PORT_NUM (PORT_NUM),
        .PORT_W   (PORT_W)
    ) u_arb (
        .req     (~pfifo_empty),
        .last    (last_grant),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Select the granted FIFO's lane and decide whether the word now on it
    // closes the packet, either by its own eop or by hitting the length cap.
    always_comb begin
        lane    = pfifo_rdata[int'(gnt)*WORD_W +: WORD_W];
        eop_in  = lane[EOP_BIT];
        len_hit = (wcnt == CNT_W'(MAX_LEN - 1)) && !eop_in;
        pkt_end = rd_vld && (eop_in || len_hit);
    end

    // Keep reading the granted FIFO until the closing word is presented;
    // stopping on that word keeps the next packet untouched in the FIFO.
    always_comb begin
        pfifo_re = '0;
        if (!rst_125m && state == READ && !pkt_end) begin
            pfifo_re[gnt] = 1'b1;
        end
    end

    // Scheduler FSM plus the registered output stage. A word on pfifo_rdata
    // in cycle t appears on dst_* in cycle t+1; error pulses ride with it.
    always_ff @(posedge clk_125m or posedge rst_125m) begin
        if (rst_125m) begin
            state      <= IDLE;
            gnt        <= '0;
            last_grant <= PORT_W'(PORT_NUM - 1);
            wcnt       <= '0;
            gap_cnt    <= '0;
            rd_vld     <= 1'b0;
            dst_vld    <= 1'b0;
            dst_data   <= '0;
            dst_sop    <= 1'b0;
            dst_eop    <= 1'b0;
            dst_port   <= '0;
            err_sop    <= 1'b0;
            err_len    <= 1'b0;
            pkt_total  <= '0;
        end else begin
            rd_vld  <= |pfifo_re;
            dst_vld <= 1'b0;
            dst_sop <= 1'b0;
            dst_eop <= 1'b0;
            err_sop <= 1'b0;
            err_len <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_any && !dst_afull) begin
                        gnt   <= arb_idx;
                        wcnt  <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    if (rd_vld) begin
                        dst_vld  <= 1'b1;
                        dst_data <= lane[DATA_W-1:0];
                        dst_port <= gnt;
                        // the first word is always marked sop; a missing
                        // sop is reported rather than dropping the packet
                        dst_sop  <= (wcnt == '0) ? 1'b1 : lane[SOP_BIT];
                        err_sop  <= (wcnt == '0) && !lane[SOP_BIT];
                        dst_eop  <= eop_in || len_hit;
                        err_len  <= len_hit;
                        wcnt     <= wcnt + CNT_W'(1);
                        if (eop_in || len_hit) begin
                            pkt_total  <= pkt_total + 16'd1;
                            last_grant <= gnt;
                            gap_cnt    <= '0;
                            state      <= GAP;
                        end
                    end
                end
                GAP: begin
                    // give the FIFO's registered empty flag time to settle
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pfifo_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_pfifo_rr_sched
// Self-checking bench for pfifo_rr_sched. A behavioural FIFO bank feeds the
// scheduler; every packet pushed also queues its expected output words, which
// a monitor pops and compares as dst_vld words appear.
// ---------------------------------------------------------------------------
module tb_pfifo_rr_sched;
    import pfifo_pkg::*;

    localparam int PORT_NUM = 4;
    localparam int PORT_W   = 2;
    localparam int MAX_LEN  = 8;
    localparam int GAP_CYC  = 2;

    logic                       clk_125m = 1'b0;
    logic                       rst_125m = 1'b1;
    logic [PORT_NUM-1:0]        pfifo_empty;
    logic [PORT_NUM*WORD_W-1:0] pfifo_rdata;
    logic [PORT_NUM-1:0]        pfifo_re;
    logic                       dst_afull = 1'b0;
    logic                       dst_vld;
    logic [DATA_W-1:0]          dst_data;
    logic                       dst_sop;
    logic                       dst_eop;
    logic [PORT_W-1:0]          dst_port;
    logic                       err_sop;
    logic                       err_len;
    logic [15:0]                pkt_total;

    typedef struct {
        logic [PORT_W-1:0] port;
        logic              sop;
        logic              eop;
        logic [15:0]       data;
        logic              esop;
        logic              elen;
        int                gap;
    } exp_t;

    exp_t        exp_q[$];
    logic [17:0] fq[PORT_NUM][$];
    int          errors = 0;
    int          checks = 0;
    int          cycle = 0;
    int          last_eop_cyc = -100;
    int          re_cnt[PORT_NUM];
    int          exp_pkts = 0;

    pfifo_rr_sched #(
        .PORT_NUM (PORT_NUM),
        .PORT_W   (PORT_W),
        .MAX_LEN  (MAX_LEN),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk_125m    (clk_125m),
        .rst_125m    (rst_125m),
        .pfifo_empty (pfifo_empty),
        .pfifo_rdata (pfifo_rdata),
        .pfifo_re    (pfifo_re),
        .dst_afull   (dst_afull),
        .dst_vld     (dst_vld),
        .dst_data    (dst_data),
        .dst_sop     (dst_sop),
        .dst_eop     (dst_eop),
        .dst_port    (dst_port),
        .err_sop     (err_sop),
        .err_len     (err_len),
        .pkt_total   (pkt_total)
    );

    // 125 MHz-ish clock
    always #4 clk_125m = ~clk_125m;

    always @(posedge clk_125m) cycle++;

    // Behavioural FIFO bank: a read strobe presents the next word one cycle
    // later; empty is registered and reflects the queue after the read.
    always @(posedge clk_125m or posedge rst_125m) begin
        if (rst_125m) begin
            for (int i = 0; i < PORT_NUM; i++) fq[i].delete();
            pfifo_rdata <= '0;
            pfifo_empty <= '1;
        end else begin
            for (int i = 0; i < PORT_NUM; i++) begin
                if (pfifo_re[i] && fq[i].size() > 0)
                    pfifo_rdata[i*WORD_W +: WORD_W] <= fq[i].pop_front();
                pfifo_empty[i] <= (fq[i].size() == 0);
            end
        end
    end

    // Single comparison point: every check in the bench goes through here
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h required=0x%0h", tag, obs, req);
        end
    endtask

    // Per-cycle monitor: read-enable sanity plus scoreboard comparison
    task automatic monitorCycle();
        exp_t e;
        checkOutput("re_onehot0", 32'($onehot0(pfifo_re)), 32'd1);
        for (int i = 0; i < PORT_NUM; i++) if (pfifo_re[i]) re_cnt[i]++;
        if (!dst_vld) begin
            checkOutput("err_idle", {30'd0, err_sop, err_len}, 32'd0);
        end else begin
            checkOutput("unexpected_word", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("dst_port", 32'(dst_port), 32'(e.port));
                checkOutput("dst_sop",  32'(dst_sop),  32'(e.sop));
                checkOutput("dst_eop",  32'(dst_eop),  32'(e.eop));
                checkOutput("dst_data", 32'(dst_data), 32'(e.data));
                checkOutput("err_sop",  32'(err_sop),  32'(e.esop));
                checkOutput("err_len",  32'(err_len),  32'(e.elen));
                if (e.gap >= 0)
                    checkOutput("idle_gap", 32'(cycle - last_eop_cyc - 1), 32'(e.gap));
            end
            if (dst_eop) last_eop_cyc = cycle;
        end
    endtask

    always @(negedge clk_125m) begin
        if (!rst_125m) monitorCycle();
    end

    // Load one packet into a FIFO and queue the words the scheduler should emit
    task automatic applyStimulus(input int port, input int len, input bit bad_sop,
                                 input bit no_eop, input logic [15:0] base, input int gap);
        exp_t e;
        logic is_eop;
        for (int k = 0; k < len; k++) begin
            is_eop = (k == len - 1) && !no_eop;
            fq[port].push_back({(k == 0) && !bad_sop, is_eop, base + 16'(k)});
            if (k < MAX_LEN) begin
                e.port = PORT_W'(port);
                e.sop  = (k == 0);
                e.elen = (k == MAX_LEN - 1) && !is_eop;
                e.eop  = is_eop || e.elen;
                e.data = base + 16'(k);
                e.esop = (k == 0) && bad_sop;
                e.gap  = (k == 0) ? gap : -1;
                exp_q.push_back(e);
                if (e.eop) exp_pkts++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_125m);
        #1;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
        repeat (GAP_CYC + 3) tick();
    endtask

    task automatic doReset();
        rst_125m = 1'b1;
        exp_q.delete();
        exp_pkts = 0;
        repeat (2) tick();
        rst_125m = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < PORT_NUM; i++) re_cnt[i] = 0;

        // reset state
        repeat (3) tick();
        checkOutput("rst_re",        32'(pfifo_re),  32'd0);
        checkOutput("rst_vld",       32'(dst_vld),   32'd0);
        checkOutput("rst_pkt_total", 32'(pkt_total), 32'd0);
        checkOutput("rst_err",       {30'd0, err_sop, err_len}, 32'd0);
        rst_125m = 1'b0;
        tick();

        // single 4-word packet on port 0
        re_cnt[0] = 0;
        applyStimulus(0, 4, 1'b0, 1'b0, 16'hA000, -1);
        waitDrain(40);
        checkOutput("single_re_cycles", 32'(re_cnt[0]), 32'd4);
        checkOutput("single_pkt_total", 32'(pkt_total), 32'(exp_pkts));

        // round robin across ports 0, 1, 3 straight after reset
        doReset();
        applyStimulus(0, 3, 1'b0, 1'b0, 16'hA100, -1);
        applyStimulus(1, 2, 1'b0, 1'b0, 16'hA200, GAP_CYC + 2);
        applyStimulus(3, 5, 1'b0, 1'b0, 16'hA300, GAP_CYC + 2);
        applyStimulus(0, 2, 1'b0, 1'b0, 16'hA400, GAP_CYC + 2);
        waitDrain(100);
        checkOutput("rr_pkt_total", 32'(pkt_total), 32'(exp_pkts));

        // downstream almost-full holds the scheduler in IDLE
        dst_afull = 1'b1;
        tick();
        re_cnt[2] = 0;
        applyStimulus(2, 3, 1'b0, 1'b0, 16'hA500, -1);
        repeat (6) tick();
        checkOutput("afull_no_re",   32'(re_cnt[2]),     32'd0);
        checkOutput("afull_pending", 32'(exp_q.size()),  32'd3);
        dst_afull = 1'b0;
        @(negedge clk_125m);
        checkOutput("afull_release_same", 32'(pfifo_re), 32'd0);
        @(negedge clk_125m);
        checkOutput("afull_release_next", 32'(pfifo_re), 32'b0100);
        waitDrain(40);

        // missing sop on the first word
        applyStimulus(1, 3, 1'b1, 1'b0, 16'hA600, -1);
        waitDrain(40);

        // length abort at MAX_LEN, then a normal packet after GAP and IDLE
        re_cnt[3] = 0;
        applyStimulus(3, MAX_LEN, 1'b0, 1'b1, 16'hA700, -1);
        applyStimulus(3, 2, 1'b0, 1'b0, 16'hA800, GAP_CYC + 2);
        waitDrain(80);
        checkOutput("abort_re_cycles", 32'(re_cnt[3]),  32'(MAX_LEN + 2));
        checkOutput("abort_pkt_total", 32'(pkt_total), 32'(exp_pkts));

        // reset in the middle of a packet
        applyStimulus(2, 6, 1'b0, 1'b0, 16'hA900, -1);
        repeat (4) tick();
        checkOutput("mid_pkt_re", 32'(pfifo_re), 32'b0100);
        rst_125m = 1'b1;
        exp_q.delete();
        exp_pkts = 0;
        #1;
        checkOutput("mid_rst_re",        32'(pfifo_re),  32'd0);
        checkOutput("mid_rst_vld",       32'(dst_vld),   32'd0);
        checkOutput("mid_rst_pkt_total", 32'(pkt_total), 32'd0);
        repeat (2) tick();
        rst_125m = 1'b0;
        tick();
        applyStimulus(0, 2, 1'b0, 1'b0, 16'hAB00, -1);
        applyStimulus(2, 2, 1'b0, 1'b0, 16'hAA00, GAP_CYC + 2);
        waitDrain(60);
        checkOutput("post_rst_pkt_total", 32'(pkt_total), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
